// File: rtl/sprite_pixel_engine.sv
// sprite_pixel_engine: three-sprite priority compositor with a per-frame descriptor latch.
// Define SPRITE_HFLIP_EN to honour descriptor bit 30 as a horizontal mirror.
module sprite_pixel_engine #(
  parameter int          SPR_SIZE   = 32,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [31:0] sprite1_in,
  input  logic [31:0] sprite2_in,
  input  logic [31:0] sprite3_in,
  output logic [9:0]  addr_ship,
  output logic [9:0]  addr_pig,
  output logic [9:0]  addr_bee,
  input  logic [23:0] M_ship,
  input  logic [23:0] M_pig,
  input  logic [23:0] M_bee,
  output logic [23:0] rgb_out,
  output logic        frame_latch
);
  localparam int AW = $clog2(SPR_SIZE);
  logic [2:0][31:0] shadow_q;
  logic [2:0][9:0]  addr_d, addr_q;
  logic [2:0]       hit_d, hit0_q, hit1_q, opq;
  logic             act0_q, act1_q, fl_q, latch, active;
  logic [23:0]      rgb_d, rgb_q;
  logic             unused_bits;
  assign latch  = hcount == '0 && vcount == 10'(V_ACTIVE);
  assign active = hcount < 10'(H_ACTIVE) && vcount < 10'(V_ACTIVE);
  assign unused_bits = ^{shadow_q[0][30:20], shadow_q[1][30:20], shadow_q[2][30:20]};
  for (genvar i = 0; i < 3; i++) begin : g_spr
    logic [10:0]   x, y, h, v, dx, dy;
    logic [AW-1:0] cx;
    logic          unused_hi;
    assign x  = {1'b0, shadow_q[i][9:0]};
    assign y  = {1'b0, shadow_q[i][19:10]};
    assign h  = {1'b0, hcount};
    assign v  = {1'b0, vcount};
    assign dx = h - x;
    assign dy = v - y;
    assign unused_hi = ^{dx[10:AW], dy[10:AW]};
    // 11-bit bounds keep a sprite near the right edge from wrapping onto column 0
    assign hit_d[i] = shadow_q[i][31] && h >= x && h < x + 11'(SPR_SIZE) &&
                      v >= y && v < y + 11'(SPR_SIZE);
`ifdef SPRITE_HFLIP_EN
    assign cx = shadow_q[i][30] ? AW'(SPR_SIZE - 1) - dx[AW-1:0] : dx[AW-1:0];
`else
    assign cx = dx[AW-1:0];
`endif
    assign addr_d[i] = hit_d[i] ? {dy[AW-1:0], cx} : '0;
  end
  assign opq = {hit1_q[2] && M_bee  != TRANSP_KEY,
                hit1_q[1] && M_pig  != TRANSP_KEY,
                hit1_q[0] && M_ship != TRANSP_KEY};
  always_comb rgb_d = !act1_q ? '0 : opq[0] ? M_ship : opq[1] ? M_pig : opq[2] ? M_bee : BG_COLOR;
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      addr_q   <= '0;
      hit0_q   <= '0;
      hit1_q   <= '0;
      act0_q   <= 1'b0;
      act1_q   <= 1'b0;
      fl_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      if (latch) shadow_q <= {sprite3_in, sprite2_in, sprite1_in};
      fl_q   <= latch;
      addr_q <= addr_d;
      hit0_q <= hit_d;
      hit1_q <= hit0_q;
      act0_q <= active;
      act1_q <= act0_q;
      rgb_q  <= rgb_d;
    end
  end
  assign addr_ship   = addr_q[0];
  assign addr_pig    = addr_q[1];
  assign addr_bee    = addr_q[2];
  assign rgb_out     = rgb_q;
  assign frame_latch = fl_q;
endmodule

// File: tb/tb_sprite_pixel_engine.sv
// tb_sprite_pixel_engine: directed scoreboard bench for the sprite compositor.
module tb_sprite_pixel_engine;
  logic        clk = 1'b0, reset = 1'b1;
  logic [9:0]  hcount = '0, vcount = '0;
  logic [31:0] sprite1_in = '0, sprite2_in = '0, sprite3_in = '0;
  logic [9:0]  addr_ship, addr_pig, addr_bee;
  logic [23:0] M_ship, M_pig, M_bee, rgb_out;
  logic        frame_latch;
  logic [23:0] rom_ship [1024];
  logic [23:0] rom_pig  [1024];
  logic [23:0] rom_bee  [1024];
  int cyc = 0, checks = 0, fails = 0;
  bit no_rgb = 0;
  typedef struct {int due; int kind; logic [23:0] exp; string tag;} chk_t;
  chk_t q[$];
  string kn [5] = '{"rgb_out", "addr_ship", "addr_pig", "addr_bee", "frame_latch"};

  sprite_pixel_engine dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .sprite1_in(sprite1_in), .sprite2_in(sprite2_in), .sprite3_in(sprite3_in),
    .addr_ship(addr_ship), .addr_pig(addr_pig), .addr_bee(addr_bee),
    .M_ship(M_ship), .M_pig(M_pig), .M_bee(M_bee),
    .rgb_out(rgb_out), .frame_latch(frame_latch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    M_ship <= rom_ship[addr_ship];
    M_pig  <= rom_pig[addr_pig];
    M_bee  <= rom_bee[addr_bee];
  end

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        logic [23:0] a;
        a = q[i].kind == 0 ? rgb_out : q[i].kind == 1 ? {14'b0, addr_ship} :
            q[i].kind == 2 ? {14'b0, addr_pig} : q[i].kind == 3 ? {14'b0, addr_bee} :
            {23'b0, frame_latch};
        checks++;
        if (a !== q[i].exp) begin
          fails++;
          $display("FAIL %s %s cyc=%0d got %h expected %h", kn[q[i].kind], q[i].tag, cyc, a, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [23:0] exp, input int h, input int v);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp; c.tag = $sformatf("(%0d,%0d)", h, v);
    q.push_back(c);
  endtask

  task automatic px(input int h, input int v, input int a0, input int a1, input int a2,
                    input logic [23:0] rgb);
    @(negedge clk);
    reset = 1'b0; hcount = 10'(h); vcount = 10'(v);
    push(cyc + 1, 1, 24'(a0), h, v);
    push(cyc + 1, 2, 24'(a1), h, v);
    push(cyc + 1, 3, 24'(a2), h, v);
    push(cyc + 1, 4, {23'b0, h == 0 && v == 480}, h, v);
    if (!no_rgb) push(cyc + 3, 0, rgb, h, v);
  endtask

  task automatic rst_px(input int h, input int v);
    @(negedge clk);
    reset = 1'b1; hcount = 10'(h); vcount = 10'(v);
    for (int k = 1; k <= 4; k++) push(cyc + 1, k, '0, h, v);
    for (int d = 1; d <= 3; d++) push(cyc + d, 0, '0, h, v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) px(700, 500, 0, 0, 0, 24'h0);
  endtask

  int a_l, a_r;
  logic [23:0] e_l, e_r;
  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom_ship[i] = 24'hA00000 | 24'(i);
      rom_pig[i]  = 24'hB00000 | 24'(i);
      rom_bee[i]  = 24'hC00000 | 24'(i);
    end
    rst_px(0, 0);
    rst_px(0, 0);
    sprite1_in = {1'b1, 1'b0, 10'd0, 10'd100, 10'd200};
    px(0, 480, 0, 0, 0, 24'h0);
    px(200, 100, 0, 0, 0, 24'hA00000);
    px(231, 131, 1023, 0, 0, 24'hA003FF);
    px(205, 103, 101, 0, 0, 24'hA00065);
    px(232, 131, 0, 0, 0, 24'h0);
    px(199, 100, 0, 0, 0, 24'h0);
    px(200, 132, 0, 0, 0, 24'h0);
    idle(2);
    rom_ship[0] = 24'hFF00FF;
    rom_pig[0]  = 24'h00FF00;
    sprite1_in = {1'b1, 1'b0, 10'd0, 10'd300, 10'd300};
    sprite2_in = {1'b1, 1'b0, 10'd0, 10'd300, 10'd300};
    px(0, 480, 0, 0, 0, 24'h0);
    px(300, 300, 0, 0, 0, 24'h00FF00);
    px(301, 300, 1, 1, 0, 24'hA00001);
    px(300, 301, 32, 32, 0, 24'hA00020);
    idle(2);
    rom_ship[0] = 24'h123456;
    px(300, 300, 0, 0, 0, 24'h123456);
    sprite3_in = {1'b1, 1'b0, 10'd0, 10'd0, 10'd630};
    px(0, 480, 0, 0, 0, 24'h0);
    px(630, 0, 0, 0, 0, 24'hC00000);
    px(639, 0, 0, 0, 9, 24'hC00009);
    px(10, 1, 0, 0, 0, 24'h0);
    px(21, 1, 0, 0, 0, 24'h0);
    px(645, 0, 0, 0, 15, 24'h0);
    px(635, 31, 0, 0, 997, 24'hC003E5);
    idle(2);
    rom_bee[1] = 24'hFF00FF;
    px(631, 0, 0, 0, 1, 24'h0);
    sprite1_in = {1'b1, 1'b0, 10'd0, 10'd300, 10'd400};
    px(0, 200, 0, 0, 0, 24'h0);
    px(405, 300, 0, 0, 0, 24'h0);
    px(300, 300, 0, 0, 0, 24'h123456);
    px(1, 480, 0, 0, 0, 24'h0);
    px(405, 300, 0, 0, 0, 24'h0);
    px(0, 480, 0, 0, 0, 24'h0);
    px(405, 300, 5, 0, 0, 24'hA00005);
    px(300, 300, 0, 0, 0, 24'h00FF00);
`ifdef SPRITE_HFLIP_EN
    a_l = 31; a_r = 0;  e_l = 24'hA0001F; e_r = 24'h123456;
`else
    a_l = 0;  a_r = 31; e_l = 24'h123456; e_r = 24'hA0001F;
`endif
    sprite1_in = {1'b1, 1'b1, 10'd0, 10'd10, 10'd10};
    sprite2_in = '0;
    sprite3_in = '0;
    px(0, 480, 0, 0, 0, 24'h0);
    px(10, 10, a_l, 0, 0, e_l);
    px(41, 10, a_r, 0, 0, e_r);
    idle(2);
    no_rgb = 1;
    px(10, 10, a_l, 0, 0, 24'h0);
    px(41, 10, a_r, 0, 0, 24'h0);
    no_rgb = 0;
    rst_px(20, 10);
    px(10, 10, 0, 0, 0, 24'h0);
    px(41, 10, 0, 0, 0, 24'h0);
    px(0, 480, 0, 0, 0, 24'h0);
    px(10, 10, a_l, 0, 0, e_l);
    idle(3);
    repeat (5) @(negedge clk);
    checks++;
    if (rgb_out !== 24'h0) begin
      fails++;
      $display("FAIL rgb_out idle got %h expected 000000", rgb_out);
    end
    checks++;
    if (addr_ship !== 10'd0) begin
      fails++;
      $display("FAIL addr_ship idle got %h expected 0", addr_ship);
    end
    checks++;
    if (addr_pig !== 10'd0) begin
      fails++;
      $display("FAIL addr_pig idle got %h expected 0", addr_pig);
    end
    checks++;
    if (addr_bee !== 10'd0) begin
      fails++;
      $display("FAIL addr_bee idle got %h expected 0", addr_bee);
    end
    checks++;
    if (frame_latch !== 1'b0) begin
      fails++;
      $display("FAIL frame_latch idle got %b expected 0", frame_latch);
    end
    #1;
    foreach (q[i]) begin
      checks++;
      fails++;
      $display("FAIL %s %s never checked, expected %h", kn[q[i].kind], q[i].tag, q[i].exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
